// File: rtl/frogger_pkg.sv
// Shared keycode constants, direction/state types and decode helpers for the frog key controller.
// KEY_AUTOREPEAT_EN adds the HOLD state used for press-and-hold auto-repeat.
package frogger_pkg;

    localparam logic [15:0] KEY_LEFT  = 16'h0050;
    localparam logic [15:0] KEY_RIGHT = 16'h004F;
    localparam logic [15:0] KEY_UP    = 16'h0052;
    localparam logic [15:0] KEY_DOWN  = 16'h0051;
    localparam logic [15:0] KEY_FROG1 = 16'h0059;
    localparam logic [15:0] KEY_FROG2 = 16'h005A;
    localparam logic [15:0] KEY_FROG3 = 16'h005B;

    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

`ifdef KEY_AUTOREPEAT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_FIRE, ST_HOLD} key_state_t;
`else
    typedef enum logic {ST_IDLE, ST_FIRE} key_state_t;
`endif

    typedef struct packed {
        logic valid;
        dir_t dir;
    } arrow_t;

    function automatic arrow_t decode_arrow(input logic [15:0] kc);
        arrow_t a;
        a.valid = 1'b1;
        a.dir   = DIR_UP;
        case (kc)
            KEY_LEFT:  a.dir = DIR_LEFT;
            KEY_RIGHT: a.dir = DIR_RIGHT;
            KEY_UP:    a.dir = DIR_UP;
            KEY_DOWN:  a.dir = DIR_DOWN;
            default:   a.valid = 1'b0;
        endcase
        return a;
    endfunction

    // LED order is {left, up, down, right}
    function automatic logic [3:0] dir_to_led(input dir_t d);
        logic [3:0] led;
        case (d)
            DIR_LEFT:  led = 4'b1000;
            DIR_UP:    led = 4'b0100;
            DIR_DOWN:  led = 4'b0010;
            default:   led = 4'b0001;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/frogger_key_ctrl_frame_tick_gen.sv
// Rising-edge detector on the Clk-domain frame_clk level; emits a one-cycle frame_tick.
module frame_tick_gen (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic frame_clk_i,
    output logic frame_tick_o
);

    logic frame_clk_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            frame_clk_q <= 1'b0;
        end else begin
            frame_clk_q <= frame_clk_i;
        end
    end

    assign frame_tick_o = frame_clk_i & ~frame_clk_q;

endmodule

// File: rtl/frogger_key_ctrl.sv
// Turns the raw USB keycode into frame-aligned one-shot frog moves and a sticky frog select.
// Define KEY_AUTOREPEAT_EN to enable press-and-hold auto-repeat (HOLD state and frame counter).
module frogger_key_ctrl
    import frogger_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 20,
    parameter int unsigned REPEAT_RATE  = 8
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] keycode,
    input  logic        frame_clk,
    output logic        up,
    output logic        down,
    output logic        left,
    output logic        right,
    output logic [1:0]  frog_sel,
    output logic [2:0]  frog_active,
    output logic [3:0]  last_dir
);

    if (REPEAT_DELAY < 1 || REPEAT_DELAY > 63) begin : g_bad_delay
        $error("REPEAT_DELAY must be within 1..63");
    end
    if (REPEAT_RATE < 1 || REPEAT_RATE > 63) begin : g_bad_rate
        $error("REPEAT_RATE must be within 1..63");
    end

    logic       frame_tick;
    arrow_t     dec_q, dec_prev_q;
    logic       new_press;
    logic       pend_valid_q, pend_valid_d;
    dir_t       pend_dir_q, pend_dir_d;
    key_state_t state_q, state_d;
    dir_t       dir_q, dir_d;
    logic [3:0] last_dir_q, last_dir_d;
    logic [1:0] frog_sel_q, frog_sel_d;
    logic       consume;

    frame_tick_gen u_frame_tick_gen (
        .clk_i       (Clk),
        .rst_ni      (Reset_n),
        .frame_clk_i (frame_clk),
        .frame_tick_o(frame_tick)
    );

    assign new_press = dec_q.valid && (dec_q != dec_prev_q);

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [5:0] DELAY6 = 6'(REPEAT_DELAY);
    localparam logic [5:0] RATE6  = 6'(REPEAT_RATE);

    logic [5:0] frame_cnt_q, frame_cnt_d;
    logic       held_same;

    assign held_same = dec_q.valid && (dec_q.dir == dir_q);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`endif

    always_comb begin
        frog_sel_d = frog_sel_q;
        case (keycode)
            KEY_FROG1: frog_sel_d = 2'd1;
            KEY_FROG2: frog_sel_d = 2'd2;
            KEY_FROG3: frog_sel_d = 2'd3;
            default:   frog_sel_d = frog_sel_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        last_dir_d = last_dir_q;
        consume    = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        frame_cnt_d = frame_cnt_q;
`endif
        // The counter is loaded on entry to FIRE (DELAY for a press, RATE for a repeat)
        // so FIRE->HOLD carries the right reload value forward unchanged.
        case (state_q)
            ST_IDLE: begin
                if (frame_tick && pend_valid_q) begin
                    consume = 1'b1;
                    if (frog_sel_q != 2'd0) begin
                        state_d    = ST_FIRE;
                        dir_d      = pend_dir_q;
                        last_dir_d = dir_to_led(pend_dir_q);
`ifdef KEY_AUTOREPEAT_EN
                        frame_cnt_d = DELAY6;
`endif
                    end
                end
            end
            ST_FIRE: begin
                if (frame_tick) begin
                    if (pend_valid_q) begin
                        consume    = 1'b1;
                        dir_d      = pend_dir_q;
                        last_dir_d = dir_to_led(pend_dir_q);
`ifdef KEY_AUTOREPEAT_EN
                        frame_cnt_d = DELAY6;
                    end else if (held_same) begin
                        state_d = ST_HOLD;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
`ifdef KEY_AUTOREPEAT_EN
            ST_HOLD: begin
                if (frame_tick) begin
                    if (pend_valid_q) begin
                        consume     = 1'b1;
                        state_d     = ST_FIRE;
                        dir_d       = pend_dir_q;
                        last_dir_d  = dir_to_led(pend_dir_q);
                        frame_cnt_d = DELAY6;
                    end else if (!held_same) begin
                        state_d = ST_IDLE;
                    end else if (frame_cnt_q <= 6'd1) begin
                        state_d     = ST_FIRE;
                        frame_cnt_d = RATE6;
                    end else begin
                        frame_cnt_d = frame_cnt_q - 6'd1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_dir_d   = pend_dir_q;
        if (new_press) begin
            pend_valid_d = 1'b1;
            pend_dir_d   = dec_q.dir;
        end else if (consume) begin
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            dec_q        <= '0;
            dec_prev_q   <= '0;
            pend_valid_q <= 1'b0;
            pend_dir_q   <= DIR_UP;
            state_q      <= ST_IDLE;
            dir_q        <= DIR_UP;
            last_dir_q   <= '0;
            frog_sel_q   <= '0;
        end else begin
            dec_q        <= decode_arrow(keycode);
            dec_prev_q   <= dec_q;
            pend_valid_q <= pend_valid_d;
            pend_dir_q   <= pend_dir_d;
            state_q      <= state_d;
            dir_q        <= dir_d;
            last_dir_q   <= last_dir_d;
            frog_sel_q   <= frog_sel_d;
        end
    end

    always_comb begin
        case (frog_sel_q)
            2'd1:    frog_active = 3'b001;
            2'd2:    frog_active = 3'b010;
            2'd3:    frog_active = 3'b100;
            default: frog_active = 3'b000;
        endcase
    end

    assign up       = (state_q == ST_FIRE) && (dir_q == DIR_UP);
    assign down     = (state_q == ST_FIRE) && (dir_q == DIR_DOWN);
    assign left     = (state_q == ST_FIRE) && (dir_q == DIR_LEFT);
    assign right    = (state_q == ST_FIRE) && (dir_q == DIR_RIGHT);
    assign frog_sel = frog_sel_q;
    assign last_dir = last_dir_q;

endmodule

// File: tb/tb_frogger_key_ctrl.sv
// Scoreboard bench for frogger_key_ctrl: expected move pulses are queued by the stimulus
// and popped by a monitor whenever a direction output rises.
module tb_frogger_key_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [15:0] keycode;
    logic        frame_clk;
    logic        up, down, left, right;
    logic [1:0]  frog_sel;
    logic [2:0]  frog_active;
    logic [3:0]  last_dir;

    typedef struct {
        logic [3:0] vec;   // {up, down, left, right}
        int         frame;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   frame_no;
    int   rise_cyc = 0;
    int   abort_cyc = 0;
    bit   abort_armed = 1'b0;

    localparam logic [3:0] V_UP    = 4'b1000;
    localparam logic [3:0] V_DOWN  = 4'b0100;
    localparam logic [3:0] V_LEFT  = 4'b0010;
    localparam logic [3:0] V_RIGHT = 4'b0001;

    frogger_key_ctrl #(
        .REPEAT_DELAY(3),
        .REPEAT_RATE (2)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .keycode    (keycode),
        .frame_clk  (frame_clk),
        .up         (up),
        .down       (down),
        .left       (left),
        .right      (right),
        .frog_sel   (frog_sel),
        .frog_active(frog_active),
        .last_dir   (last_dir)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // 16-cycle frame: 8 low, 8 high
    initial begin
        frame_clk = 1'b0;
        frame_no  = 0;
        forever begin
            repeat (8) @(negedge Clk);
            frame_clk = 1'b1;
            frame_no++;
            rise_cyc = cyc;
            repeat (8) @(negedge Clk);
            frame_clk = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    initial begin : monitor
        logic [3:0] prev_v;
        logic [3:0] cur;
        int         start_frame;
        exp_t       e;
        prev_v      = 4'b0000;
        start_frame = 0;
        forever begin
            @(posedge Clk);
            #1;
            cur = {up, down, left, right};
            if (cur !== prev_v) begin
                if (prev_v != 4'b0000) begin
                    if (abort_armed) begin
                        chk("reset_drop_latency", cyc - abort_cyc, 1);
                    end else begin
                        chk("pulse_len_frames", frame_no - start_frame, 1);
                        chk("fall_latency", cyc - rise_cyc, 1);
                    end
                end
                if (cur != 4'b0000) begin
                    chk("onehot_dirs", {31'd0, $onehot(cur)}, 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse: got %b in frame %0d, expected none", cur, frame_no);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pulse_dir", {28'd0, cur}, {28'd0, e.vec});
                        chk("pulse_frame", frame_no, e.frame);
                        chk("rise_latency", cyc - rise_cyc, 1);
                    end
                    start_frame = frame_no;
                end
                prev_v = cur;
            end
        end
    end

    task automatic key(input logic [15:0] kc, input int n);
        keycode = kc;
        repeat (n) @(negedge Clk);
    endtask

    task automatic mid_frame();
        @(posedge frame_clk);
        repeat (3) @(negedge Clk);
    endtask

    task automatic wait_frames(input int n);
        repeat (n) @(posedge frame_clk);
        repeat (2) @(negedge Clk);
    endtask

    initial begin : stimulus
        int f;
        Reset_n = 1'b0;
        keycode = 16'h0052;
        repeat (3) @(negedge Clk);
        chk("reset_dirs", {28'd0, up, down, left, right}, 0);
        chk("reset_frog_sel", {30'd0, frog_sel}, 0);
        chk("reset_frog_active", {29'd0, frog_active}, 0);
        chk("reset_last_dir", {28'd0, last_dir}, 0);
        Reset_n = 1'b1;
        wait_frames(2);
        keycode = 16'h0000;
        chk("no_frog_sel_after_up", {30'd0, frog_sel}, 0);
        chk("no_frog_last_dir", {28'd0, last_dir}, 0);

        key(16'h005A, 1);
        keycode = 16'h0000;
        chk("sel2_frog_sel", {30'd0, frog_sel}, 2);
        chk("sel2_frog_active", {29'd0, frog_active}, 3'b010);
        repeat (4) @(negedge Clk);
        chk("sel2_sticky", {30'd0, frog_sel}, 2);
        key(16'h0059, 1);
        keycode = 16'h0000;
        chk("sel1_frog_sel", {30'd0, frog_sel}, 1);
        chk("sel1_frog_active", {29'd0, frog_active}, 3'b001);

        // short press, released long before the tick
        mid_frame();
        f = frame_no;
        exp_q.push_back('{V_LEFT, f + 1});
        key(16'h0050, 5);
        keycode = 16'h0000;
        wait_frames(2);
        chk("short_last_dir", {28'd0, last_dir}, 4'b1000);

        // second press during FIRE fires next frame
        mid_frame();
        f = frame_no;
        exp_q.push_back('{V_UP, f + 1});
        exp_q.push_back('{V_DOWN, f + 2});
        key(16'h0052, 3);
        keycode = 16'h0000;
        @(posedge frame_clk);
        repeat (3) @(negedge Clk);
        key(16'h0051, 3);
        keycode = 16'h0000;
        wait_frames(2);
        chk("b2b_last_dir", {28'd0, last_dir}, 4'b0010);

        // later press within a frame overwrites the earlier one
        mid_frame();
        f = frame_no;
        exp_q.push_back('{V_RIGHT, f + 1});
        key(16'h0050, 2);
        key(16'h0000, 2);
        key(16'h004F, 2);
        keycode = 16'h0000;
        wait_frames(2);
        chk("overwrite_last_dir", {28'd0, last_dir}, 4'b0001);

        // reset in the middle of a pulse with another press pending
        mid_frame();
        f = frame_no;
        exp_q.push_back('{V_UP, f + 1});
        key(16'h0052, 3);
        keycode = 16'h0000;
        @(posedge frame_clk);
        repeat (3) @(negedge Clk);
        key(16'h0051, 2);
        keycode = 16'h0000;
        @(negedge Clk);
        abort_armed = 1'b1;
        abort_cyc   = cyc;
        Reset_n     = 1'b0;
        repeat (2) @(negedge Clk);
        chk("abort_dirs", {28'd0, up, down, left, right}, 0);
        chk("abort_frog_sel", {30'd0, frog_sel}, 0);
        chk("abort_last_dir", {28'd0, last_dir}, 0);
        Reset_n = 1'b1;
        @(negedge Clk);
        abort_armed = 1'b0;
        wait_frames(2);

        key(16'h005B, 1);
        keycode = 16'h0000;
        chk("sel3_frog_sel", {30'd0, frog_sel}, 3);
        chk("sel3_frog_active", {29'd0, frog_active}, 3'b100);

        // hold right for 12 frames
        mid_frame();
        f = frame_no;
`ifdef KEY_AUTOREPEAT_EN
        exp_q.push_back('{V_RIGHT, f + 1});
        exp_q.push_back('{V_RIGHT, f + 5});
        exp_q.push_back('{V_RIGHT, f + 8});
        exp_q.push_back('{V_RIGHT, f + 11});
`else
        exp_q.push_back('{V_RIGHT, f + 1});
`endif
        keycode = 16'h004F;
        repeat (12) @(posedge frame_clk);
        repeat (3) @(negedge Clk);
        keycode = 16'h0000;
        wait_frames(2);
        chk("hold_last_dir", {28'd0, last_dir}, 4'b0001);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
